// File: rtl/processor_pkg.sv
// Shared definitions for the pipeline memory path.
//   - SZ_* : access size codes used on mem_size / ram_size
//   - arb_state_e : unified memory arbiter state encoding
//   - ADDR_W_DEF / DATA_W_DEF : default bus widths
package processor_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_IF_ACC   = 3'd1,
        ST_MEM_ACC  = 3'd2,
        ST_IF_DONE  = 3'd3,
        ST_MEM_DONE = 3'd4,
        ST_MEM_ERR  = 3'd5
    } arb_state_e;

endpackage

// File: rtl/mem_align_check.sv
// Combinational alignment check for a data access.
//   size_i       : access size code (SZ_BYTE / SZ_HALF / SZ_WORD)
//   addr_lo_i    : two least significant address bits
//   misaligned_o : 1 when the address is not naturally aligned for the size
// The reserved size code 2'b11 is reported as aligned.
module mem_align_check
    import processor_pkg::*;
(
    input  logic [1:0] size_i,
    input  logic [1:0] addr_lo_i,
    output logic       misaligned_o
);

    always_comb begin
        misaligned_o = 1'b0;
        case (size_i)
            SZ_HALF: misaligned_o = addr_lo_i[0];
            SZ_WORD: misaligned_o = (addr_lo_i != 2'b00);
            default: misaligned_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port RAM between instruction fetch (IF) and load/store (MEM).
//   clk, reset          : clock, asynchronous active-high reset
//   if_*                : fetch request / response, if_flush cancels the fetch response
//   mem_*               : load/store request / response, mem_err flags misalignment
//   ram_*               : registered RAM command, ram_rdata/ram_ready handshake back
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | arbitrate between IF and MEM, register the winning command
// ST_IF_ACC   | fetch on the RAM, waiting for ram_ready
// ST_MEM_ACC  | load/store on the RAM, waiting for ram_ready
// ST_IF_DONE  | if_valid pulse (masked by a same-cycle if_flush)
// ST_MEM_DONE | mem_valid pulse, mem_err = 0
// ST_MEM_ERR  | mem_valid pulse, mem_err = 1, no RAM access was made
module unified_mem_arbiter
    import processor_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_err,
    output logic              mem_stall,
    output logic              ram_en,
    output logic              ram_we,
    output logic [1:0]        ram_size,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ready
);

    localparam int STREAK_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    arb_state_e          state_q;
    logic [STREAK_W-1:0] streak_q;
    logic                drop_q;
    logic                if_valid_q;
    logic                mem_valid_q;
    logic                mem_err_q;
    logic                ram_en_q;
    logic                ram_we_q;
    logic [1:0]          ram_size_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [DATA_W-1:0]   ram_wdata_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic [DATA_W-1:0]   mem_rdata_q;

    logic mem_misaligned;
    logic if_starved;

    mem_align_check u_align (
        .size_i       (mem_size),
        .addr_lo_i    (mem_addr[1:0]),
        .misaligned_o (mem_misaligned)
    );

    // IF has watched STARVE_LIMIT MEM grants in a row and must go next.
    assign if_starved = if_req && (streak_q == STREAK_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            streak_q    <= '0;
            drop_q      <= 1'b0;
            if_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_err_q   <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_size_q  <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            if_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_err_q   <= 1'b0;

            // A withdrawn fetch request ends the starvation streak in any state.
            if (!if_req) begin
                streak_q <= '0;
            end

            case (state_q)
                ST_IDLE: begin
                    drop_q <= 1'b0;
                    if (mem_req && mem_misaligned) begin
                        state_q     <= ST_MEM_ERR;
                        mem_valid_q <= 1'b1;
                        mem_err_q   <= 1'b1;
                        mem_rdata_q <= '0;
                    end else if (mem_req && !if_starved) begin
                        state_q     <= ST_MEM_ACC;
                        ram_en_q    <= 1'b1;
                        ram_we_q    <= mem_we;
                        ram_size_q  <= mem_size;
                        ram_addr_q  <= mem_addr;
                        ram_wdata_q <= mem_wdata;
                        if (if_req && (streak_q != STREAK_MAX)) begin
                            streak_q <= streak_q + 1'b1;
                        end
                    end else if (if_req) begin
                        state_q     <= ST_IF_ACC;
                        ram_en_q    <= 1'b1;
                        ram_we_q    <= 1'b0;
                        ram_size_q  <= SZ_WORD;
                        ram_addr_q  <= if_addr;
                        ram_wdata_q <= '0;
                        streak_q    <= '0;
                    end
                end

                ST_IF_ACC: begin
                    if (if_flush) begin
                        drop_q <= 1'b1;
                    end
                    if (ram_ready) begin
                        ram_en_q   <= 1'b0;
                        ram_we_q   <= 1'b0;
                        if_rdata_q <= ram_rdata;
                        // A flush on the completing cycle discards the data as well.
                        if (drop_q || if_flush) begin
                            state_q <= ST_IDLE;
                            drop_q  <= 1'b0;
                        end else begin
                            state_q    <= ST_IF_DONE;
                            if_valid_q <= 1'b1;
                        end
                    end
                end

                ST_MEM_ACC: begin
                    if (ram_ready) begin
                        ram_en_q    <= 1'b0;
                        ram_we_q    <= 1'b0;
                        mem_rdata_q <= ram_rdata;
                        state_q     <= ST_MEM_DONE;
                        mem_valid_q <= 1'b1;
                    end
                end

                ST_IF_DONE, ST_MEM_DONE, ST_MEM_ERR: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // The fetch pulse is registered but still masked by a flush in the same cycle.
    assign if_valid  = if_valid_q & ~if_flush;
    assign if_rdata  = if_rdata_q;
    assign if_stall  = if_req & ~if_valid;
    assign mem_valid = mem_valid_q;
    assign mem_err   = mem_err_q;
    assign mem_rdata = mem_rdata_q;
    assign mem_stall = mem_req & ~mem_valid;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_size  = ram_size_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;

    localparam int STARVE = 4;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_valid;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic        mem_stall;
    logic        ram_en;
    logic        ram_we;
    logic [1:0]  ram_size;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_ready;

    int n_cmp = 0;
    int n_bad = 0;

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(STARVE)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_valid  (if_valid),
        .if_rdata  (if_rdata),
        .if_stall  (if_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_size  (mem_size),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_valid (mem_valid),
        .mem_rdata (mem_rdata),
        .mem_err   (mem_err),
        .mem_stall (mem_stall),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_size  (ram_size),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_ready (ram_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM contents as a pure function of the address.
    function automatic logic [31:0] data_of(input logic [31:0] a);
        if (a == 32'h8) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign ram_rdata = ram_ready ? data_of(ram_addr) : 32'hBAD0_BAD0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Transaction view: the RAM is either free, busy with one fetch, busy with one
    // load/store, or the cycle after a transaction where its result is reported.
    localparam int P_FREE = 0, P_FETCH = 1, P_DATA = 2, P_REPORT = 3;
    int          m_phase;
    int          m_mem_wins;      // MEM grants in a row while IF kept asking
    bit          m_cancel;        // current fetch was flushed
    logic        e_ram_en, e_ram_we, e_ifv, e_memv, e_err;
    logic [1:0]  e_ram_size;
    logic [31:0] e_ram_addr, e_ram_wdata, e_if_rdata, e_mem_rdata;
    logic        if_done_seen, mem_done_seen;

    task automatic model_reset();
        m_phase = P_FREE; m_mem_wins = 0; m_cancel = 0;
        e_ram_en = 0; e_ram_we = 0; e_ifv = 0; e_memv = 0; e_err = 0;
        e_ram_size = 0; e_ram_addr = 0; e_ram_wdata = 0;
        e_if_rdata = 0; e_mem_rdata = 0;
    endtask

    task automatic model_step();
        bit misaligned;
        e_ifv = 0; e_memv = 0; e_err = 0;
        if (!if_req) m_mem_wins = 0;
        case (m_phase)
            P_FREE: begin
                m_cancel = 0;
                misaligned = mem_req && ((mem_addr % (32'd1 << mem_size)) != 0);
                if (misaligned) begin
                    m_phase = P_REPORT; e_memv = 1; e_err = 1; e_mem_rdata = 0;
                end else if (mem_req && !(if_req && m_mem_wins >= STARVE)) begin
                    m_phase = P_DATA;
                    e_ram_en = 1; e_ram_we = mem_we; e_ram_size = mem_size;
                    e_ram_addr = mem_addr; e_ram_wdata = mem_wdata;
                    if (if_req) m_mem_wins++;
                end else if (if_req) begin
                    m_phase = P_FETCH;
                    e_ram_en = 1; e_ram_we = 0; e_ram_size = 2'b10;
                    e_ram_addr = if_addr; e_ram_wdata = 0;
                    m_mem_wins = 0;
                end
            end
            P_FETCH: begin
                if (if_flush) m_cancel = 1;
                if (ram_ready) begin
                    e_ram_en = 0; e_ram_we = 0;
                    e_if_rdata = data_of(e_ram_addr);
                    if (m_cancel) begin
                        m_phase = P_FREE; m_cancel = 0;
                    end else begin
                        m_phase = P_REPORT; e_ifv = 1;
                    end
                end
            end
            P_DATA: begin
                if (ram_ready) begin
                    e_ram_en = 0; e_ram_we = 0;
                    e_mem_rdata = data_of(e_ram_addr);
                    m_phase = P_REPORT; e_memv = 1;
                end
            end
            default: m_phase = P_FREE;
        endcase
    endtask

    always @(negedge clk) begin
        logic exp_ifv;
        if (reset) model_reset();
        exp_ifv = e_ifv & ~if_flush;
        chk("ram_en",    {31'b0, ram_en},    {31'b0, e_ram_en});
        chk("ram_we",    {31'b0, ram_we},    {31'b0, e_ram_we});
        chk("ram_size",  {30'b0, ram_size},  {30'b0, e_ram_size});
        chk("ram_addr",  ram_addr,           e_ram_addr);
        chk("ram_wdata", ram_wdata,          e_ram_wdata);
        chk("if_valid",  {31'b0, if_valid},  {31'b0, exp_ifv});
        chk("if_rdata",  if_rdata,           e_if_rdata);
        chk("if_stall",  {31'b0, if_stall},  {31'b0, if_req & ~exp_ifv});
        chk("mem_valid", {31'b0, mem_valid}, {31'b0, e_memv});
        chk("mem_err",   {31'b0, mem_err},   {31'b0, e_err});
        chk("mem_rdata", mem_rdata,          e_mem_rdata);
        chk("mem_stall", {31'b0, mem_stall}, {31'b0, mem_req & ~e_memv});
        if_done_seen  = exp_ifv;
        mem_done_seen = e_memv;
        if (!reset) model_step();
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_waddr();
        return 32'($urandom_range(0, 65535)) << 2;
    endfunction

    task automatic new_mem();
        logic [31:0] a;
        mem_req   = 1'b1;
        mem_we    = 1'($urandom_range(0, 1));
        mem_size  = 2'($urandom_range(0, 2));
        mem_wdata = $urandom;
        a = 32'($urandom_range(0, 262143));
        if ($urandom_range(0, 5) != 0) a = a & ~((32'd1 << mem_size) - 1);
        mem_addr = a;
    endtask

    logic [31:0] starve_exp [6];

    initial begin
        reset = 1; if_req = 0; if_addr = 0; if_flush = 0;
        mem_req = 0; mem_we = 0; mem_size = 0; mem_addr = 0; mem_wdata = 0;
        ram_ready = 0;
        if_done_seen = 0; mem_done_seen = 0;
        model_reset();
        tick(); tick();
        @(negedge clk);
        chk("rst_ram_en", {31'b0, ram_en}, 32'd0);
        chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
        tick();
        reset = 0;

        // Single fetch, zero-wait RAM.
        tick();
        ram_ready = 1; if_req = 1; if_addr = 32'h8;
        @(negedge clk);
        chk("t1_c0_stall", {31'b0, if_stall}, 32'd1);
        chk("t1_c0_ram_en", {31'b0, ram_en}, 32'd0);
        tick(); @(negedge clk);
        chk("t1_c1_ram_en", {31'b0, ram_en}, 32'd1);
        chk("t1_c1_ram_addr", ram_addr, 32'h8);
        chk("t1_c1_stall", {31'b0, if_stall}, 32'd1);
        tick(); @(negedge clk);
        chk("t1_c2_valid", {31'b0, if_valid}, 32'd1);
        chk("t1_c2_rdata", if_rdata, 32'h0050_0093);
        chk("t1_c2_stall", {31'b0, if_stall}, 32'd0);
        tick(); if_req = 0;

        // Conflict: MEM first, then IF.
        tick();
        if_req = 1; if_addr = 32'h100;
        mem_req = 1; mem_we = 0; mem_size = 2'b10; mem_addr = 32'h40;
        tick(); @(negedge clk);
        chk("t2_first_addr", ram_addr, 32'h40);
        tick(); @(negedge clk);
        chk("t2_mem_valid", {31'b0, mem_valid}, 32'd1);
        tick(); mem_req = 0;
        tick(); @(negedge clk);
        chk("t2_second_addr", ram_addr, 32'h100);
        chk("t2_second_en", {31'b0, ram_en}, 32'd1);
        tick(); @(negedge clk);
        chk("t2_if_valid", {31'b0, if_valid}, 32'd1);
        tick(); if_req = 0;

        // Starvation: four MEM grants, then IF, then MEM again (streak back at 0).
        starve_exp = '{32'h80, 32'h80, 32'h80, 32'h80, 32'h200, 32'h80};
        tick();
        if_req = 1; if_addr = 32'h200;
        mem_req = 1; mem_we = 0; mem_size = 2'b10; mem_addr = 32'h80;
        for (int g = 0; g < 6; g++) begin
            tick(); @(negedge clk);
            chk("t3_grant_addr", ram_addr, starve_exp[g]);
            tick(); tick();
        end
        if_req = 0; mem_req = 0;

        // Flush during a slow fetch.
        tick();
        ram_ready = 0; if_req = 1; if_addr = 32'h300;
        tick(); @(negedge clk);
        chk("t4_c1_ram_en", {31'b0, ram_en}, 32'd1);
        tick(); if_flush = 1;
        @(negedge clk);
        chk("t4_c2_valid", {31'b0, if_valid}, 32'd0);
        tick(); if_flush = 0; if_req = 0;
        tick(); ram_ready = 1;
        @(negedge clk);
        chk("t4_c4_ram_en", {31'b0, ram_en}, 32'd1);
        tick(); ram_ready = 0;
        @(negedge clk);
        chk("t4_c5_ram_en", {31'b0, ram_en}, 32'd0);
        chk("t4_c5_valid", {31'b0, if_valid}, 32'd0);
        tick(); @(negedge clk);
        chk("t4_c6_valid", {31'b0, if_valid}, 32'd0);

        // Misaligned word store.
        tick();
        mem_req = 1; mem_we = 1; mem_size = 2'b10; mem_addr = 32'h42; mem_wdata = 32'h1234;
        @(negedge clk);
        chk("t5_c0_ram_en", {31'b0, ram_en}, 32'd0);
        tick(); @(negedge clk);
        chk("t5_valid", {31'b0, mem_valid}, 32'd1);
        chk("t5_err", {31'b0, mem_err}, 32'd1);
        chk("t5_rdata", mem_rdata, 32'd0);
        chk("t5_c1_ram_en", {31'b0, ram_en}, 32'd0);
        tick(); mem_req = 0;
        @(negedge clk);
        chk("t5_c2_valid", {31'b0, mem_valid}, 32'd0);

        // Asynchronous reset in the middle of a MEM access.
        tick();
        ram_ready = 0; mem_req = 1; mem_we = 0; mem_size = 2'b10; mem_addr = 32'h44;
        tick(); @(negedge clk);
        chk("t6_ram_en_before", {31'b0, ram_en}, 32'd1);
        tick(); mem_req = 0;
        #2 reset = 1;
        #1;
        chk("t6_ram_en", {31'b0, ram_en}, 32'd0);
        chk("t6_ram_addr", ram_addr, 32'd0);
        chk("t6_ram_we", {31'b0, ram_we}, 32'd0);
        chk("t6_mem_valid", {31'b0, mem_valid}, 32'd0);
        chk("t6_mem_rdata", mem_rdata, 32'd0);
        chk("t6_if_valid", {31'b0, if_valid}, 32'd0);
        tick(); tick();
        reset = 0; ram_ready = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t6_post_valid", {31'b0, mem_valid}, 32'd0);
            chk("t6_post_en", {31'b0, ram_en}, 32'd0);
            tick();
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            logic fl_prev;
            tick();
            fl_prev   = if_flush;
            ram_ready = ($urandom_range(0, 2) != 0);
            if_flush  = ($urandom_range(0, 15) == 0);
            if (if_req) begin
                if (if_done_seen || fl_prev) begin
                    if ($urandom_range(0, 1) == 1) if_addr = rand_waddr();
                    else if_req = 0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = rand_waddr();
            end
            if (mem_req) begin
                if (mem_done_seen) begin
                    if ($urandom_range(0, 3) != 0) new_mem();
                    else mem_req = 0;
                end else if ($urandom_range(0, 63) == 0) begin
                    mem_req = 0;
                end
            end else if ($urandom_range(0, 1) == 0) begin
                new_mem();
            end
        end
        tick();
        if_req = 0; mem_req = 0; if_flush = 0;
        repeat (8) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
